azadi_wb_ctrl: RTL

AZADI_WB_CTRL -- requirements
Module: azadi_wb_ctrl

---
 rtl/azadi_wb_ctrl_pkg.sv | 41 ++++
 rtl/azadi_wb_ctrl_if.sv | 21 ++
 rtl/azadi_wb_ctrl_prog_sync.sv | 24 ++
 rtl/azadi_wb_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/azadi_wb_ctrl_pkg.sv
// Shared definitions for the azadi_wb_ctrl block: register offsets, bit indices,
// CPB floor, reset-sequencer states and byte-merge / clamp helpers.
package azadi_wb_ctrl_pkg;

    localparam logic [7:0] REG_CTRL    = 8'h00;
    localparam logic [7:0] REG_CPB     = 8'h04;
    localparam logic [7:0] REG_STATUS  = 8'h08;
    localparam logic [7:0] REG_SCRATCH = 8'h0C;

    localparam int CTRL_SOFT_RST   = 0;
    localparam int CTRL_PROG_FORCE = 1;
    localparam int CTRL_PROG_MASK  = 2;
    localparam int CTRL_IRQ_EN     = 3;

    localparam int STAT_IN_RESET  = 0;
    localparam int STAT_PROG_SYNC = 1;
    localparam int STAT_PROG_EDGE = 2;

    localparam logic [15:0] CPB_MIN = 16'd16;

    typedef enum logic {
        ST_ASSERT = 1'b0,
        ST_RUN    = 1'b1
    } rst_state_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [15:0] clamp_cpb(input logic [15:0] v);
        return (v < CPB_MIN) ? CPB_MIN : v;
    endfunction

endpackage

// File: rtl/azadi_wb_ctrl_if.sv
// Wishbone classic slave bundle for azadi_wb_ctrl; master drives controls, slave answers.
interface azadi_wb_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/azadi_wb_ctrl_prog_sync.sv
// Two-flop synchronizer for the programming button with a one-cycle rising-edge pulse.
module azadi_wb_ctrl_prog_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);
    logic [1:0] sync_q;
    logic       last_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_i};
            last_q <= sync_q[1];
        end
    end

    assign sync_o = sync_q[1];
    assign rise_o = sync_q[1] & ~last_q;
endmodule

// File: rtl/azadi_wb_ctrl.sv
// SoC management controller: Wishbone register file, SoC reset sequencer, UART divisor
// and programming-button interrupt. Optional macro LA_CPB_OVERRIDE_EN adds la_* override.
module azadi_wb_ctrl
    import azadi_wb_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          RST_HOLD  = 16,
    parameter logic [15:0] CPB_RESET = 16'd87
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    azadi_wb_ctrl_if.slave    wb,
    input  logic              prog_i,
    output logic              prog_o,
    output logic              soc_rst_no,
    output logic [15:0]       clks_per_bit_o,
    output logic              irq_o
`ifdef LA_CPB_OVERRIDE_EN
    ,
    input  logic [15:0]       la_data_in,
    input  logic [15:0]       la_oenb
`endif
);
    localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);

    rst_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        force_q, force_d;
    logic        mask_q, mask_d;
    logic        irq_en_q, irq_en_d;
    logic [15:0] cpb_q, cpb_d;
    logic [31:0] scratch_q, scratch_d;
    logic        prog_edge_q, prog_edge_d;
    logic        irq_q, irq_d;
    logic [15:0] cpb_out_q, cpb_out_d;

    logic        prog_sync, prog_rise;
    logic        in_win, access, wr, rd, soft_rst, edge_clr;
    logic [7:0]  off;
    logic [15:0] cpb_src;

    azadi_wb_ctrl_prog_sync u_prog_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (prog_i),
        .sync_o  (prog_sync),
        .rise_o  (prog_rise)
    );

    assign in_win   = (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign off      = wb.wbs_adr_i[7:0];
    assign access   = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q & in_win;
    assign wr       = access & wb.wbs_we_i;
    assign rd       = access & ~wb.wbs_we_i;
    assign soft_rst = wr && (off == REG_CTRL) && wb.wbs_sel_i[0] && wb.wbs_dat_i[CTRL_SOFT_RST];
    assign edge_clr = wr && (off == REG_STATUS) && wb.wbs_sel_i[0] && wb.wbs_dat_i[STAT_PROG_EDGE];

`ifdef LA_CPB_OVERRIDE_EN
    assign cpb_src = (la_oenb == 16'h0000) ? clamp_cpb(la_data_in) : cpb_q;
`else
    assign cpb_src = cpb_q;
`endif

    // Reset sequencer next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ASSERT: begin
                if (soft_rst) begin
                    cnt_d = 16'd0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RUN: begin
                if (soft_rst) begin
                    state_d = ST_ASSERT;
                    cnt_d   = 16'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_ASSERT;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Register file, bus response and interrupt next state
    always_comb begin
        ack_d       = access;
        rdata_d     = 32'h0;
        force_d     = force_q;
        mask_d      = mask_q;
        irq_en_d    = irq_en_q;
        cpb_d       = cpb_q;
        scratch_d   = scratch_q;
        prog_edge_d = prog_rise | (prog_edge_q & ~edge_clr);
        irq_d       = prog_edge_q & irq_en_q;
        cpb_out_d   = (state_q == ST_ASSERT) ? cpb_src : cpb_out_q;

        if (wr) begin
            case (off)
                REG_CTRL: begin
                    if (wb.wbs_sel_i[0]) begin
                        force_d  = wb.wbs_dat_i[CTRL_PROG_FORCE];
                        mask_d   = wb.wbs_dat_i[CTRL_PROG_MASK];
                        irq_en_d = wb.wbs_dat_i[CTRL_IRQ_EN];
                    end
                end
                REG_CPB: begin
                    cpb_d = clamp_cpb({wb.wbs_sel_i[1] ? wb.wbs_dat_i[15:8] : cpb_q[15:8],
                                       wb.wbs_sel_i[0] ? wb.wbs_dat_i[7:0]  : cpb_q[7:0]});
                end
                REG_SCRATCH: scratch_d = merge_bytes(scratch_q, wb.wbs_dat_i, wb.wbs_sel_i);
                default: ;
            endcase
        end

        if (rd) begin
            case (off)
                REG_CTRL:    rdata_d = {28'h0, irq_en_q, mask_q, force_q, 1'b0};
                REG_CPB:     rdata_d = {16'h0, cpb_q};
                REG_STATUS:  rdata_d = {29'h0, prog_edge_q, prog_sync, state_q == ST_ASSERT};
                REG_SCRATCH: rdata_d = scratch_q;
                default:     rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ack_q       <= 1'b0;
            rdata_q     <= 32'h0;
            force_q     <= 1'b0;
            mask_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            cpb_q       <= CPB_RESET;
            scratch_q   <= 32'h0;
            prog_edge_q <= 1'b0;
            irq_q       <= 1'b0;
            cpb_out_q   <= CPB_RESET;
        end else begin
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            force_q     <= force_d;
            mask_q      <= mask_d;
            irq_en_q    <= irq_en_d;
            cpb_q       <= cpb_d;
            scratch_q   <= scratch_d;
            prog_edge_q <= prog_edge_d;
            irq_q       <= irq_d;
            cpb_out_q   <= cpb_out_d;
        end
    end

    assign wb.wbs_ack_o   = ack_q;
    assign wb.wbs_dat_o   = rdata_q;
    assign soc_rst_no     = (state_q == ST_RUN);
    assign prog_o         = force_q | (prog_sync & ~mask_q);
    assign clks_per_bit_o = cpb_out_q;
    assign irq_o          = irq_q;
endmodule
